program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_assembler.sv | 47 ++++
 rtl/program_loader.sv | 166 ++++++++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    HDR_REG,
    INSTR,
    REGS,
    RUN,
    ERR
  } state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned REG_BYTES   = 8;
  localparam int unsigned MAX_REGS    = 31;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/byte_assembler.sv
// LSB-first byte assembler: shifts bytes in from the top and flags the last
// byte of a 4- or 8-byte group combinationally, with the completed value.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic [CNT_W-1:0]  width_sel,
  output logic              done_c,
  output logic [DATA_W-1:0] word_c
);

  logic [DATA_W-1:0] data_q, data_d, shifted_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A 4-byte group ends up in the upper half of the shift register.
  always_comb begin
    shifted_c = {in_data, data_q[DATA_W-1:8]};
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_c    = 1'b0;
    word_c    = (width_sel == CNT_W'(INSTR_BYTES)) ?
                {32'd0, shifted_c[DATA_W-1:32]} : shifted_c;
    if (in_valid) begin
      data_d = shifted_c;
      if (cnt_q == width_sel - CNT_W'(1)) begin
        done_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a header, writes instruction memory and register-file
// init values from a byte stream, then releases the core from reset.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_INSTR = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_write,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          reg_write,
  output logic [4:0]    reg_windex,
  output logic [63:0]   reg_wdata,
  output logic          core_reset,
  output logic          load_done,
  output logic          error
);

  state_t state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [4:0]  r_q, r_d;
  logic [15:0] cnt_q, cnt_d;

  logic          imem_write_q, imem_write_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    reg_windex_q, reg_windex_d;
  logic [63:0]   reg_wdata_q, reg_wdata_d;
  logic          core_reset_q, core_reset_d;
  logic          load_done_q, load_done_d;
  logic          error_q, error_d;

  logic              accept_c;
  logic              asm_valid_c;
  logic              asm_done_c;
  logic [CNT_W-1:0]  width_sel_c;
  logic [DATA_W-1:0] asm_word_c;

  // Ready follows the state directly so it drops the moment reset is raised.
  assign rx_ready    = !reset && (state_q inside {HDR_LO, HDR_HI, HDR_REG, INSTR, REGS});
  assign accept_c    = rx_valid && rx_ready;
  assign asm_valid_c = accept_c && (state_q inside {INSTR, REGS});
  assign width_sel_c = (state_q == REGS) ? CNT_W'(REG_BYTES) : CNT_W'(INSTR_BYTES);

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (asm_valid_c),
    .in_data   (rx_data),
    .width_sel (width_sel_c),
    .done_c    (asm_done_c),
    .word_c    (asm_word_c)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    r_d          = r_q;
    cnt_d        = cnt_q;
    imem_write_d = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    reg_write_d  = 1'b0;
    reg_windex_d = reg_windex_q;
    reg_wdata_d  = reg_wdata_q;

    unique case (state_q)
      HDR_LO: if (accept_c) begin
        n_d     = {8'd0, rx_data};
        state_d = HDR_HI;
      end
      HDR_HI: if (accept_c) begin
        n_d     = {rx_data, n_q[7:0]};
        state_d = HDR_REG;
      end
      HDR_REG: if (accept_c) begin
        r_d   = rx_data[4:0];
        cnt_d = '0;
        if ((n_q == 16'd0) || (32'(n_q) > MAX_INSTR) || (32'(rx_data) > MAX_REGS))
          state_d = ERR;
        else
          state_d = INSTR;
      end
      INSTR: if (asm_done_c) begin
        imem_write_d = 1'b1;
        imem_wdata_d = asm_word_c[31:0];
        imem_addr_d  = AW'(cnt_q);
        if (cnt_q == n_q - 16'd1) begin
          cnt_d   = '0;
          state_d = (r_q != 5'd0) ? REGS : RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REGS: if (asm_done_c) begin
        reg_write_d  = 1'b1;
        reg_wdata_d  = asm_word_c;
        reg_windex_d = 5'(cnt_q) + 5'd1;
        if (cnt_q == {11'd0, r_q} - 16'd1) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    // Core release lags the RUN entry by one cycle.
    core_reset_d = (state_q != RUN);
    load_done_d  = (state_q == RUN);
    error_d      = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HDR_LO;
      n_q          <= '0;
      r_q          <= '0;
      cnt_q        <= '0;
      imem_write_q <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      reg_write_q  <= 1'b0;
      reg_windex_q <= '0;
      reg_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      imem_write_q <= imem_write_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      reg_write_q  <= reg_write_d;
      reg_windex_q <= reg_windex_d;
      reg_wdata_q  <= reg_wdata_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

  assign imem_write = imem_write_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign reg_write  = reg_write_q;
  assign reg_windex = reg_windex_q;
  assign reg_wdata  = reg_wdata_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader: a default instance plus a
// MAX_INSTR=4 instance sharing the same input stream.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rx_ready, imem_write, reg_write, core_reset, load_done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0]  reg_windex;
  logic [63:0] reg_wdata;

  logic        s_rx_ready, s_imem_write, s_reg_write, s_core_reset, s_load_done, s_error;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [4:0]  s_reg_windex;
  logic [63:0] s_reg_wdata;

  program_loader #(.MAX_INSTR(1024), .AW(10)) u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_write(imem_write), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .reg_write(reg_write), .reg_windex(reg_windex),
    .reg_wdata(reg_wdata), .core_reset(core_reset), .load_done(load_done),
    .error(error)
  );

  program_loader #(.MAX_INSTR(4), .AW(2)) u_small (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(s_rx_ready), .imem_write(s_imem_write), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .reg_write(s_reg_write), .reg_windex(s_reg_windex),
    .reg_wdata(s_reg_wdata), .core_reset(s_core_reset), .load_done(s_load_done),
    .error(s_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Strobe capture on the falling edge.
  int          n_imem = 0, n_reg = 0, n_imem_small = 0, n_glitch = 0;
  logic [9:0]  cap_iaddr [64];
  logic [31:0] cap_idata [64];
  logic [4:0]  cap_ridx  [64];
  logic [63:0] cap_rdata [64];
  logic        prev_iw = 1'b0, prev_rw = 1'b0;

  always @(negedge clk) begin
    if (imem_write && n_imem < 64) begin
      cap_iaddr[n_imem] = imem_addr;
      cap_idata[n_imem] = imem_wdata;
    end
    if (imem_write) n_imem++;
    if (reg_write && n_reg < 64) begin
      cap_ridx[n_reg]  = reg_windex;
      cap_rdata[n_reg] = reg_wdata;
    end
    if (reg_write) n_reg++;
    if (s_imem_write || s_reg_write) n_imem_small++;
    if ((imem_write && prev_iw) || (reg_write && prev_rw) || (imem_write && reg_write))
      n_glitch++;
    prev_iw = imem_write;
    prev_rw = reg_write;
  end

  typedef struct {
    int unsigned     len;
    logic [191:0]    stream;
    int unsigned     max_idle;
    int unsigned     ni;
    logic [3:0][31:0] idata;
    int unsigned     nr;
    logic [1:0][63:0] rdata;
    logic            run;
    logic            err;
    logic            rdy;
    logic            err_small;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mkv(input int unsigned len, input logic [191:0] raw,
                               input int unsigned idle, input int unsigned ni,
                               input logic [127:0] idata, input int unsigned nr,
                               input logic [127:0] rdata, input logic run,
                               input logic err, input logic rdy, input logic err_small);
    vec_t v;
    v.len       = len;
    v.stream    = raw << (8 * (24 - len));
    v.max_idle  = idle;
    v.ni        = ni;
    v.idata     = idata;
    v.nr        = nr;
    v.rdata     = rdata;
    v.run       = run;
    v.err       = err;
    v.rdy       = rdy;
    v.err_small = err_small;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b, input int unsigned max_idle);
    int unsigned idle;
    idle = (max_idle == 0) ? 0 : $urandom_range(max_idle, 0);
    repeat (idle) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    if (!rx_ready) begin
      n_checks++;
      $display("FAIL send_timeout: byte %0h not accepted within 50 cycles", b);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_ready",   64'(rx_ready),   64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_load_done",  64'(load_done),  64'd0);
    check("rst_error",      64'(error),      64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_reg_wdata",  reg_wdata,       64'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int ib, rb, sb, gb;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vecs[0] = mkv(11, 192'h0200001300500093001000, 0, 2,
                  {64'h0, 32'h00100093, 32'h00500013}, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[1] = mkv(23, 192'h010002_13005000_0A00000000000000_FFFFFFFFFFFFFFFF, 0, 1,
                  {96'h0, 32'h00500013}, 2, {64'hFFFFFFFFFFFFFFFF, 64'h000000000000000A},
                  1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2] = mkv(11, 192'h0200001300500093001000, 5, 2,
                  {64'h0, 32'h00100093, 32'h00500013}, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3] = mkv(3, 192'h000000, 0, 0, '0, 0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[4] = mkv(3, 192'h010020, 0, 0, '0, 0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[5] = mkv(3, 192'h050000, 0, 0, '0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[6] = mkv(19, 192'h040000_11223344_55667788_99AABBCC_DDEEFF00, 0, 4,
                  {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211}, 0, '0,
                  1'b1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 7; r++) begin
      apply_reset();
      ib = n_imem; rb = n_reg; sb = n_imem_small; gb = n_glitch;
      for (int i = 0; i < int'(vecs[r].len); i++)
        send(vecs[r].stream[191 - 8*i -: 8], vecs[r].max_idle);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_imem_count", r), 64'(n_imem - ib), 64'(vecs[r].ni));
      for (int i = 0; i < int'(vecs[r].ni); i++) begin
        check($sformatf("v%0d_imem_addr%0d", r, i), 64'(cap_iaddr[ib+i]), 64'(i));
        check($sformatf("v%0d_imem_data%0d", r, i), 64'(cap_idata[ib+i]), 64'(vecs[r].idata[i]));
      end
      check($sformatf("v%0d_reg_count", r), 64'(n_reg - rb), 64'(vecs[r].nr));
      for (int i = 0; i < int'(vecs[r].nr); i++) begin
        check($sformatf("v%0d_reg_idx%0d", r, i), 64'(cap_ridx[rb+i]), 64'(i + 1));
        check($sformatf("v%0d_reg_data%0d", r, i), cap_rdata[rb+i], vecs[r].rdata[i]);
      end
      check($sformatf("v%0d_load_done", r),  64'(load_done),  64'(vecs[r].run));
      check($sformatf("v%0d_core_reset", r), 64'(core_reset), 64'(!vecs[r].run));
      check($sformatf("v%0d_error", r),      64'(error),      64'(vecs[r].err));
      check($sformatf("v%0d_rx_ready", r),   64'(rx_ready),   64'(vecs[r].rdy));
      check($sformatf("v%0d_small_error", r), 64'(s_error),   64'(vecs[r].err_small));
      if (vecs[r].err_small) begin
        check($sformatf("v%0d_small_strobes", r), 64'(n_imem_small - sb), 64'd0);
        check($sformatf("v%0d_small_core_reset", r), 64'(s_core_reset), 64'd1);
        check($sformatf("v%0d_small_rx_ready", r), 64'(s_rx_ready), 64'd0);
      end
      check($sformatf("v%0d_strobe_shape", r), 64'(n_glitch - gb), 64'd0);
    end

    // Exact strobe and core-release timing around the final byte.
    apply_reset();
    begin
      logic [87:0] s1;
      logic [7:0]  b;
      s1 = 88'h0200001300500093001000;
      for (int i = 0; i < 11; i++) begin
        b = s1[87 - 8*i -: 8];
        send(b, 0);
      end
    end
    check("t_last_strobe",     64'(imem_write), 64'd1);
    check("t_last_addr",       64'(imem_addr),  64'd1);
    check("t_core_reset_hold", 64'(core_reset), 64'd1);
    check("t_load_done_low",   64'(load_done),  64'd0);
    @(posedge clk); #1;
    check("t_strobe_drop",     64'(imem_write), 64'd0);
    check("t_core_release",    64'(core_reset), 64'd0);
    check("t_load_done_high",  64'(load_done),  64'd1);
    check("t_rx_ready_run",    64'(rx_ready),   64'd0);
    check("t_wdata_hold",      64'(imem_wdata), 64'h00100093);

    // Reset in the middle of a word discards it; reload starts at address 0.
    apply_reset();
    ib = n_imem;
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("m_no_strobe", 64'(n_imem - ib), 64'd0);
    check("m_rx_ready_rst", 64'(rx_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    repeat (3) @(negedge clk);
    check("m_strobe_count", 64'(n_imem - ib), 64'd1);
    check("m_addr", 64'(cap_iaddr[ib]), 64'd0);
    check("m_data", 64'(cap_idata[ib]), 64'hDEADBEEF);
    check("m_load_done", 64'(load_done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
